// File: rtl/data_mem_if_if.sv
// Memory-side bus between data_mem_if (master) and the data memory (slave).
interface data_mem_if_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_mem_if.sv
// Load/store unit front end: formats byte/half/word accesses onto a word-wide memory bus.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned half/word requests instead of truncating.
module data_mem_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        require_mem_access,
  input  logic        write_to_data_mem,
  input  logic [1:0]  access_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        data_mem_access_ready_n,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misaligned,
  data_mem_if_if.master mem
);

  localparam logic [1:0] SIZE_WORD    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_BYTE    = 2'b10;
  localparam logic [1:0] SIZE_INVALID = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg, load_data_reg;
  logic [3:0]  byte_en_reg;
  logic [1:0]  off_reg, size_reg;
  logic        we_reg, uns_reg;

  logic [1:0]  lo_bits;
  logic [3:0]  byte_en_calc;
  logic [31:0] wdata_calc, rd_shift, rd_fmt;
  logic        trap, accept;

`ifdef MISALIGN_TRAP_EN
  logic misaligned_reg;
  assign trap = ((access_size == SIZE_HALF) && addr[0]) ||
                ((access_size == SIZE_WORD) && (addr[1:0] != 2'b00));
  assign misaligned = misaligned_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= (state_reg == IDLE) && require_mem_access &&
                        (access_size != SIZE_INVALID) && trap;
    end
  end
`else
  assign trap       = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign accept = require_mem_access && (access_size != SIZE_INVALID) && !trap;

  // Offending low address bits are dropped so lane selection stays naturally aligned.
  always_comb begin
    lo_bits      = addr[1:0];
    byte_en_calc = 4'b1111;
    wdata_calc   = store_data;
    case (access_size)
      SIZE_BYTE: begin
        byte_en_calc = 4'b0001 << addr[1:0];
        wdata_calc   = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        lo_bits      = {addr[1], 1'b0};
        byte_en_calc = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc   = {2{store_data[15:0]}};
      end
      default: begin
        lo_bits      = 2'b00;
        byte_en_calc = 4'b1111;
        wdata_calc   = store_data;
      end
    endcase
  end

  always_comb begin
    rd_shift = mem.mem_rdata >> {off_reg, 3'b000};
    rd_fmt   = mem.mem_rdata;
    case (size_reg)
      SIZE_BYTE: rd_fmt = uns_reg ? {24'b0, rd_shift[7:0]}
                                  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SIZE_HALF: rd_fmt = uns_reg ? {16'b0, rd_shift[15:0]}
                                  : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default:   rd_fmt = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next              = state_reg;
    mem.mem_req             = 1'b0;
    mem.mem_we              = 1'b0;
    done                    = 1'b0;
    data_mem_access_ready_n = 1'b1;
    case (state_reg)
      IDLE: begin
        data_mem_access_ready_n = 1'b0;
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = we_reg;
        if (mem.mem_ack) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      byte_en_reg   <= 4'b0000;
      off_reg       <= 2'b00;
      size_reg      <= SIZE_WORD;
      we_reg        <= 1'b0;
      uns_reg       <= 1'b0;
      load_data_reg <= 32'h0;
    end else begin
      if ((state_reg == IDLE) && accept) begin
        addr_reg    <= {addr[31:2], 2'b00};
        wdata_reg   <= wdata_calc;
        byte_en_reg <= write_to_data_mem ? byte_en_calc : 4'b0000;
        off_reg     <= lo_bits;
        size_reg    <= access_size;
        we_reg      <= write_to_data_mem;
        uns_reg     <= load_unsigned;
      end
      if ((state_reg == ACCESS) && mem.mem_ack && !we_reg) begin
        load_data_reg <= rd_fmt;
      end
    end
  end

  assign mem.mem_addr    = addr_reg;
  assign mem.mem_wdata   = wdata_reg;
  assign mem.mem_byte_en = byte_en_reg;
  assign load_data       = load_data_reg;

endmodule

// File: tb/tb_data_mem_if.sv
// Directed self-checking bench for data_mem_if; honours MISALIGN_TRAP_EN when defined.
module tb_data_mem_if;
  logic        clk = 1'b0;
  logic        rst;
  logic        require_mem_access;
  logic        write_to_data_mem;
  logic [1:0]  access_size;
  logic        load_unsigned;
  logic [31:0] addr, store_data;
  logic        data_mem_access_ready_n;
  logic [31:0] load_data;
  logic        done, misaligned;

  int errors = 0;
  int checks = 0;

  data_mem_if_if bus();

  data_mem_if dut (
    .clk                     (clk),
    .rst                     (rst),
    .require_mem_access      (require_mem_access),
    .write_to_data_mem       (write_to_data_mem),
    .access_size             (access_size),
    .load_unsigned           (load_unsigned),
    .addr                    (addr),
    .store_data              (store_data),
    .data_mem_access_ready_n (data_mem_access_ready_n),
    .load_data               (load_data),
    .done                    (done),
    .misaligned              (misaligned),
    .mem                     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One accepted transaction; inputs change and outputs are sampled on the falling edge.
  task automatic xfer(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] a, input logic [31:0] sd,
                      input logic [31:0] rd, input int waits,
                      input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input logic [31:0] exp_ld);
    int busy;
    busy = 0;
    @(negedge clk);
    require_mem_access = 1'b1;
    write_to_data_mem  = we;
    access_size        = size;
    load_unsigned      = uns;
    addr               = a;
    store_data         = sd;
    @(negedge clk);
    require_mem_access = 1'b0;
    check({tag, ".req"},   {31'b0, bus.mem_req}, 32'd1);
    check({tag, ".we"},    {31'b0, bus.mem_we}, {31'b0, we});
    check({tag, ".addr"},  bus.mem_addr, exp_addr);
    check({tag, ".be"},    {28'b0, bus.mem_byte_en}, {28'b0, exp_be});
    if (we) check({tag, ".wdata"}, bus.mem_wdata, exp_wd);
    if (data_mem_access_ready_n) busy++;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check({tag, ".hold_req"},  {31'b0, bus.mem_req}, 32'd1);
      check({tag, ".hold_addr"}, bus.mem_addr, exp_addr);
      if (data_mem_access_ready_n) busy++;
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    check({tag, ".done"}, {31'b0, done}, 32'd1);
    check({tag, ".ld"},   load_data, exp_ld);
    if (data_mem_access_ready_n) busy++;
    @(negedge clk);
    check({tag, ".done_off"}, {31'b0, done}, 32'd0);
    check({tag, ".ready"},    {31'b0, data_mem_access_ready_n}, 32'd0);
    check({tag, ".busy"},     busy, waits + 2);
    $display("xfer %s addr=%h load_data=%h busy=%0d", tag, a, load_data, busy);
  endtask

  initial begin
    rst                = 1'b1;
    require_mem_access = 1'b0;
    write_to_data_mem  = 1'b0;
    access_size        = 2'b00;
    load_unsigned      = 1'b0;
    addr               = 32'h0;
    store_data         = 32'h0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = 32'h0;
    repeat (3) @(negedge clk);
    check("rst.req",   {31'b0, bus.mem_req}, 32'd0);
    check("rst.we",    {31'b0, bus.mem_we}, 32'd0);
    check("rst.be",    {28'b0, bus.mem_byte_en}, 32'd0);
    check("rst.addr",  bus.mem_addr, 32'h0);
    check("rst.ld",    load_data, 32'h0);
    check("rst.ready", {31'b0, data_mem_access_ready_n}, 32'd0);
    check("rst.done",  {31'b0, done}, 32'd0);
    rst = 1'b0;
    $display("reset released");

    //   tag    we    size   uns   addr          store_data    mem_rdata     w  mem_addr      be       wdata         load_data
    xfer("SW",  1'b1, 2'b00, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h0,        0, 32'h00000100, 4'b1111, 32'hDEADBEEF, 32'h00000000);
    xfer("LB",  1'b0, 2'b10, 1'b0, 32'h00000203, 32'h0,        32'h80FF1234, 3, 32'h00000200, 4'b0000, 32'h0,        32'hFFFFFF80);
    xfer("LHU", 1'b0, 2'b01, 1'b1, 32'h00000202, 32'h0,        32'h80FF1234, 1, 32'h00000200, 4'b0000, 32'h0,        32'h000080FF);
    xfer("SB",  1'b1, 2'b10, 1'b0, 32'h00000101, 32'h000000AB, 32'h0,        0, 32'h00000100, 4'b0010, 32'hABABABAB, 32'h000080FF);
    xfer("SH",  1'b1, 2'b01, 1'b0, 32'h00000102, 32'h00001234, 32'h0,        2, 32'h00000100, 4'b1100, 32'h12341234, 32'h000080FF);
    xfer("LBU", 1'b0, 2'b10, 1'b1, 32'h00000201, 32'h0,        32'h80FF1234, 0, 32'h00000200, 4'b0000, 32'h0,        32'h00000012);

    // Invalid access size is ignored.
    @(negedge clk);
    require_mem_access = 1'b1;
    write_to_data_mem  = 1'b1;
    access_size        = 2'b11;
    addr               = 32'h00000400;
    @(negedge clk);
    require_mem_access = 1'b0;
    check("inv.req",   {31'b0, bus.mem_req}, 32'd0);
    check("inv.ready", {31'b0, data_mem_access_ready_n}, 32'd0);
    $display("xfer INV ignored req=%b", bus.mem_req);

    // Reset during ACCESS abandons the transaction; a late ack is ignored.
    @(negedge clk);
    require_mem_access = 1'b1;
    write_to_data_mem  = 1'b1;
    access_size        = 2'b00;
    addr               = 32'h00000300;
    store_data         = 32'h55AA55AA;
    @(negedge clk);
    require_mem_access = 1'b0;
    check("rstacc.req_before", {31'b0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstacc.req",   {31'b0, bus.mem_req}, 32'd0);
    check("rstacc.done",  {31'b0, done}, 32'd0);
    check("rstacc.ld",    load_data, 32'h0);
    check("rstacc.addr",  bus.mem_addr, 32'h0);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("lateack.done",  {31'b0, done}, 32'd0);
    check("lateack.req",   {31'b0, bus.mem_req}, 32'd0);
    check("lateack.ready", {31'b0, data_mem_access_ready_n}, 32'd0);
    $display("xfer RST abandoned req=%b done=%b", bus.mem_req, done);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    require_mem_access = 1'b1;
    write_to_data_mem  = 1'b0;
    access_size        = 2'b00;
    load_unsigned      = 1'b0;
    addr               = 32'h00000102;
    @(negedge clk);
    require_mem_access = 1'b0;
    check("lwmis.flag",  {31'b0, misaligned}, 32'd1);
    check("lwmis.req",   {31'b0, bus.mem_req}, 32'd0);
    @(negedge clk);
    check("lwmis.pulse", {31'b0, misaligned}, 32'd0);
    check("lwmis.req2",  {31'b0, bus.mem_req}, 32'd0);
    $display("xfer LWMIS trapped");
`else
    xfer("LWMIS", 1'b0, 2'b00, 1'b0, 32'h00000102, 32'h0, 32'h11223344, 0,
         32'h00000100, 4'b0000, 32'h0, 32'h11223344);
    check("lwmis.flag", {31'b0, misaligned}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_if.md
DATA_MEM_IF -- requirements
Module: data_mem_if

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: require_mem_access  in  1  start request from memory control stage.
REQ-004 SHALL have ports: write_to_data_mem  in  1  1 = store, 0 = load.
REQ-005 SHALL have ports: access_size  in  2  00 word, 01 half, 10 byte, 11 invalid.
REQ-006 SHALL have ports: load_unsigned  in  1  funct3[2] of load; 1 = zero-extend.
REQ-007 SHALL have ports: addr  in  32  byte address; store_data  in  32  store value in low bits.
REQ-008 SHALL have ports: data_mem_access_ready_n  out  1  0 = block idle and able to accept, 1 = busy.
REQ-009 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  32 (word-aligned); mem_wdata  out  32; mem_byte_en  out  4.
REQ-010 SHALL have ports: mem_rdata  in  32; mem_ack  in  1  one-cycle completion from memory.
REQ-011 SHALL have ports: load_data  out  32; done  out  1  one-cycle completion pulse; misaligned  out  1.

Function
REQ-012 SHALL implement FSM with states IDLE, ACCESS, DONE.
REQ-013 IDLE: when require_mem_access=1 and access_size!=11, SHALL latch addr, store_data, size, direction, load_unsigned, then go to ACCESS next cycle.
REQ-014 IDLE: request with access_size=11 SHALL be ignored, with state held in IDLE.
REQ-015 ACCESS: mem_req SHALL be 1, with mem_addr, mem_we, mem_wdata, and mem_byte_en stable from latched values until mem_ack.
REQ-016 ACCESS with mem_ack=1: SHALL capture the formatted read data and go to DONE; with mem_ack=0, SHALL remain in ACCESS with no timeout.
REQ-017 DONE: done SHALL be 1 for exactly one cycle, load_data valid, then go to IDLE.
REQ-018 load_data SHALL hold its value until the next load completes, and SHALL be unchanged by stores.
REQ-019 data_mem_access_ready_n SHALL be 0 only in IDLE.
REQ-020 Minimum latency SHALL be request accepted at edge N, mem_req high in cycle N+1, ack in N+1 gives done in N+2.
REQ-021 Byte enables: byte access SHALL give 0001 shifted left by addr[1:0]; half access SHALL give 0011 shifted left by addr[1]*2; word access SHALL give 1111.
REQ-022 mem_wdata SHALL use byte lanes: byte replicated to all 4 lanes, half replicated to both halves, word passed through.
REQ-023 Load formatting SHALL select the lane by addr[1:0], then sign-extend, or zero-extend when load_unsigned=1.
REQ-024 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-025 require_mem_access asserted outside IDLE SHALL be ignored, with no queuing.

Reset
REQ-026 With rst=1 at a clock edge: state SHALL go to IDLE, and mem_req, mem_we, done, and misaligned SHALL go to 0.
REQ-027 With rst=1 at a clock edge: mem_byte_en SHALL go to 0000, mem_addr, mem_wdata, and load_data SHALL go to 0, and data_mem_access_ready_n SHALL go to 0.
REQ-028 Reset during ACCESS SHALL abandon the transaction, with no done pulse and mem_req deasserted the next cycle; a late mem_ack SHALL be ignored in IDLE.

Configuration
REQ-029 With macro MISALIGN_TRAP_EN defined, a request whose half has addr[0]=1, or whose word has addr[1:0]!=00, SHALL not enter ACCESS.
REQ-030 In that case (MISALIGN_TRAP_EN defined, misaligned request), misaligned SHALL pulse 1 for one cycle and no mem_req SHALL issue.
REQ-031 Without MISALIGN_TRAP_EN, the offending low address bits SHALL be forced to 0 before lane selection and misaligned SHALL be tied 0.

Verification
REQ-032 SW: addr=0x100, store_data=0xDEADBEEF, ack after 0 wait cycles -> mem_byte_en=1111, mem_wdata=0xDEADBEEF, done at request+2.
REQ-033 LB: addr=0x203, mem_rdata=0x80FF1234, ack after 3 wait cycles -> load_data=0xFFFFFF80, done 1 cycle, ready_n high for 5 cycles.
REQ-034 LHU: addr=0x202, mem_rdata=0x80FF1234 -> load_data=0x000080FF, mem_byte_en=0000 (load, no write), mem_we=0.
REQ-035 SB: addr=0x101, store_data=0x000000AB -> mem_byte_en=0010, mem_wdata=0xABABABAB.
REQ-036 Assert rst during ACCESS -> mem_req=0 the next cycle, no done, and an ack 1 cycle later is ignored.
REQ-037 LW at addr=0x102: with MISALIGN_TRAP_EN -> misaligned=1 and no mem_req; without it -> mem_addr=0x100 with normal completion.
